// File: rtl/dmac_alu_feeder.sv
// Single-channel DMA master feeding the ALU slave port: copies a block of words
// from a source range to a destination range, one read/write pair per word.
module dmac_alu_feeder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_start,
    input  logic              opdone_clear,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  data_size,
    input  logic              src_fixed,
    input  logic              dst_fixed,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_sel,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic [1:0]        status,
    output logic              m_interrupt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        RWAIT,
        WR,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] next_src;
    logic [ADDR_W-1:0] next_dst;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  next_rem;
    logic              src_fix_q;
    logic              dst_fix_q;

    // Next-state and pointer arithmetic; outputs are derived from next_state
    // so that every output register lines up with the state it belongs to.
    always_comb begin
        next_state = state;
        next_src   = src_q;
        next_dst   = dst_q;
        next_rem   = rem_q;
        case (state)
            IDLE: begin
                if (op_start) begin
                    next_src   = src_addr;
                    next_dst   = dst_addr;
                    next_rem   = data_size;
                    next_state = (data_size == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (m_grant) next_state = RD;
            end
            RD:    next_state = RWAIT;
            RWAIT: next_state = WR;
            WR: begin
                next_rem = rem_q - LEN_W'(1);
                if (!src_fix_q) next_src = src_q + ADDR_W'(1);
                if (!dst_fix_q) next_dst = dst_q + ADDR_W'(1);
                if (next_rem == '0)  next_state = DONE;
                else if (m_grant)    next_state = RD;
                else                 next_state = REQ;
            end
            DONE: begin
                if (opdone_clear) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            src_fix_q   <= 1'b0;
            dst_fix_q   <= 1'b0;
            m_req       <= 1'b0;
            m_sel       <= 1'b0;
            m_wr        <= 1'b0;
            m_addr      <= '0;
            m_dout      <= '0;
            status      <= 2'b00;
            m_interrupt <= 1'b0;
        end else begin
            state <= next_state;
            src_q <= next_src;
            dst_q <= next_dst;
            rem_q <= next_rem;
            if (state == IDLE && op_start) begin
                src_fix_q <= src_fixed;
                dst_fix_q <= dst_fixed;
            end
            // m_dout doubles as the word buffer: read data lands here at the end of RWAIT.
            if (state == RWAIT) m_dout <= m_din;

            m_req       <= (next_state == REQ) || (next_state == RD) ||
                           (next_state == RWAIT) || (next_state == WR);
            m_sel       <= (next_state == RD) || (next_state == WR);
            m_wr        <= (next_state == WR);
            m_interrupt <= (next_state == DONE);
            if (next_state == RD)      m_addr <= next_src;
            else if (next_state == WR) m_addr <= next_dst;
            if (next_state == DONE)      status <= 2'b10;
            else if (next_state == IDLE) status <= 2'b00;
            else                         status <= 2'b01;
        end
    end

endmodule

// File: tb/tb_dmac_alu_feeder.sv
// Directed testbench for dmac_alu_feeder: a registered memory slave answers reads
// with {16'hC0DE, address} and logs every bus cycle for comparison.
module tb_dmac_alu_feeder;

    logic        clk;
    logic        reset_n;
    logic        op_start;
    logic        opdone_clear;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  data_size;
    logic        src_fixed;
    logic        dst_fixed;
    logic        m_req;
    logic        m_grant;
    logic        m_sel;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic [31:0] m_din;
    logic [1:0]  status;
    logic        m_interrupt;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic        prev_sel;
    logic        prev_wr;

    dmac_alu_feeder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .opdone_clear (opdone_clear),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .data_size    (data_size),
        .src_fixed    (src_fixed),
        .dst_fixed    (dst_fixed),
        .m_req        (m_req),
        .m_grant      (m_grant),
        .m_sel        (m_sel),
        .m_wr         (m_wr),
        .m_addr       (m_addr),
        .m_dout       (m_dout),
        .m_din        (m_din),
        .status       (status),
        .m_interrupt  (m_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // Slave model and bus monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (m_sel) begin
            if (m_wr) begin
                wr_addr_log.push_back(m_addr);
                wr_data_log.push_back(m_dout);
            end else begin
                rd_log.push_back(m_addr);
                m_din = mem_word(m_addr);
            end
            checks++;
            if (prev_sel && (prev_wr == m_wr)) begin
                errors++;
                $display("[TB] FAIL sel_repeat: m_sel high two cycles with m_wr=%0b", m_wr);
            end
        end
        prev_sel = m_sel;
        prev_wr  = m_wr;
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic start_op(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                            input logic sf, input logic df);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        data_size = n;
        src_fixed = sf;
        dst_fixed = df;
        op_start  = 1'b1;
        @(negedge clk);
        op_start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 1;
        while (!m_interrupt && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (!m_interrupt) begin
            errors++;
            $display("[TB] FAIL done_timeout: m_interrupt=%0b after %0d cycles, need 1", m_interrupt, cycles);
        end
    endtask

    task automatic wait_sel(input logic wr);
        int n = 0;
        while (!(m_sel && m_wr == wr) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(m_sel && m_wr == wr)) begin
            errors++;
            $display("[TB] FAIL sel_timeout: no m_sel with m_wr=%0b within 60 cycles", wr);
        end
    endtask

    task automatic clear_done();
        @(negedge clk);
        opdone_clear = 1'b1;
        @(negedge clk);
        opdone_clear = 1'b0;
        checks++;
        if (status !== 2'b00 || m_interrupt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear: status=%b irq=%b, need 00/0", status, m_interrupt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_req, m_sel, m_wr, m_interrupt, status, m_addr, m_dout} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: req=%b sel=%b wr=%b irq=%b status=%b addr=%h dout=%h, need all 0",
                     m_req, m_sel, m_wr, m_interrupt, status, m_addr, m_dout);
        end
        reset_n = 1'b1;
        m_grant = 1'b1;
        start_op(16'h0050, 16'h0060, 8'd4, 1'b0, 1'b0);
        wait_sel(1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_sel !== 1'b0 || m_req !== 1'b0 || m_interrupt !== 1'b0 || status !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_mid_rd: sel=%b req=%b irq=%b status=%b, need 0/0/0/00",
                     m_sel, m_req, m_interrupt, status);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (status !== 2'b00 || m_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: status=%b req=%b, need 00/0", status, m_req);
        end
        clear_logs();
    endtask

    task automatic test_copy();
        logic [15:0] exp_rd[3] = '{16'h0100, 16'h0101, 16'h0102};
        logic [15:0] exp_wa[3] = '{16'h0200, 16'h0201, 16'h0202};
        logic [31:0] exp_wd[3] = '{32'hC0DE0100, 32'hC0DE0101, 32'hC0DE0102};
        int cycles;
        clear_logs();
        m_grant = 1'b1;
        start_op(16'h0100, 16'h0200, 8'd3, 1'b0, 1'b0);
        wait_done(100, cycles);
        checks++;
        if (cycles != 11) begin
            errors++;
            $display("[TB] FAIL copy_latency: irq after %0d cycles, need 11", cycles);
        end
        checks++;
        if (status !== 2'b10) begin
            errors++;
            $display("[TB] FAIL copy_status: status=%b, need 10", status);
        end
        checks++;
        if (rd_log.size() != 3 || wr_addr_log.size() != 3) begin
            errors++;
            $display("[TB] FAIL copy_count: reads=%0d writes=%0d, need 3/3", rd_log.size(), wr_addr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_log[i] !== exp_rd[i] || wr_addr_log[i] !== exp_wa[i] || wr_data_log[i] !== exp_wd[i]) begin
                    errors++;
                    $display("[TB] FAIL copy_word%0d: rd=%h wa=%h wd=%h, need %h %h %h", i,
                             rd_log[i], wr_addr_log[i], wr_data_log[i], exp_rd[i], exp_wa[i], exp_wd[i]);
                end
            end
        end
        clear_done();
    endtask

    task automatic test_alu_push();
        logic [31:0] exp_wd[4] = '{32'hC0DE0300, 32'hC0DE0301, 32'hC0DE0302, 32'hC0DE0303};
        int cycles;
        clear_logs();
        m_grant = 1'b1;
        start_op(16'h0300, 16'h0010, 8'd4, 1'b0, 1'b1);
        wait_done(100, cycles);
        checks++;
        if (wr_addr_log.size() != 4) begin
            errors++;
            $display("[TB] FAIL push_count: writes=%0d, need 4", wr_addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_log[i] !== 16'h0010 || wr_data_log[i] !== exp_wd[i]) begin
                    errors++;
                    $display("[TB] FAIL push_word%0d: wa=%h wd=%h, need 0010 %h", i,
                             wr_addr_log[i], wr_data_log[i], exp_wd[i]);
                end
            end
        end
        clear_done();
    endtask

    task automatic test_arbitration();
        int cycles;
        clear_logs();
        m_grant = 1'b0;
        start_op(16'h0400, 16'h0500, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_req !== 1'b1 || m_sel !== 1'b0) begin
                errors++;
                $display("[TB] FAIL arb_wait%0d: req=%b sel=%b, need 1/0", i, m_req, m_sel);
            end
            @(negedge clk);
        end
        m_grant = 1'b1;
        wait_sel(1'b1);
        m_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m_req !== 1'b1 || m_sel !== 1'b0 || status !== 2'b01) begin
                errors++;
                $display("[TB] FAIL arb_regrant%0d: req=%b sel=%b status=%b, need 1/0/01", i, m_req, m_sel, status);
            end
        end
        m_grant = 1'b1;
        wait_done(100, cycles);
        checks++;
        if (wr_addr_log.size() != 2 || rd_log.size() != 2) begin
            errors++;
            $display("[TB] FAIL arb_count: reads=%0d writes=%0d, need 2/2", rd_log.size(), wr_addr_log.size());
        end else begin
            checks++;
            if (wr_addr_log[0] !== 16'h0500 || wr_data_log[0] !== 32'hC0DE0400 ||
                wr_addr_log[1] !== 16'h0501 || wr_data_log[1] !== 32'hC0DE0401) begin
                errors++;
                $display("[TB] FAIL arb_data: %h=%h %h=%h, need 0500=C0DE0400 0501=C0DE0401",
                         wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1]);
            end
        end
        clear_done();
    endtask

    task automatic test_edge_cases();
        int cycles;
        clear_logs();
        m_grant = 1'b1;
        start_op(16'h1234, 16'h5678, 8'd0, 1'b0, 1'b0);
        checks++;
        if (m_interrupt !== 1'b1 || status !== 2'b10) begin
            errors++;
            $display("[TB] FAIL size0_done: irq=%b status=%b, need 1/10", m_interrupt, status);
        end
        @(negedge clk);
        checks++;
        if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
            errors++;
            $display("[TB] FAIL size0_nobus: reads=%0d writes=%0d, need 0/0", rd_log.size(), wr_addr_log.size());
        end
        // Start and clear together in DONE: clear wins and the start is lost.
        opdone_clear = 1'b1;
        op_start     = 1'b1;
        data_size    = 8'd3;
        @(negedge clk);
        opdone_clear = 1'b0;
        op_start     = 1'b0;
        @(negedge clk);
        checks++;
        if (status !== 2'b00 || m_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_beats_start: status=%b req=%b, need 00/0", status, m_req);
        end

        clear_logs();
        start_op(16'hFFFF, 16'h0600, 8'd2, 1'b0, 1'b0);
        wait_done(100, cycles);
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000 ||
            wr_data_log.size() != 2 || wr_data_log[1] !== 32'hC0DE0000) begin
            errors++;
            $display("[TB] FAIL wrap: reads=%0d first=%h second=%h, need 2 FFFF 0000",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 16'hxxxx,
                     (rd_log.size() > 1) ? rd_log[1] : 16'hxxxx);
        end
        clear_done();

        clear_logs();
        start_op(16'h0700, 16'h0800, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        src_addr  = 16'h0900;
        dst_addr  = 16'h0A00;
        data_size = 8'd5;
        op_start  = 1'b1;
        @(negedge clk);
        op_start  = 1'b0;
        wait_done(100, cycles);
        checks++;
        if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 16'h0800 || wr_addr_log[1] !== 16'h0801 ||
            wr_data_log[1] !== 32'hC0DE0701) begin
            errors++;
            $display("[TB] FAIL busy_start: writes=%0d, need 2 to 0800/0801 with source 0700/0701",
                     wr_addr_log.size());
        end
        clear_done();
    endtask

    initial begin
        reset_n      = 1'b0;
        op_start     = 1'b0;
        opdone_clear = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        data_size    = '0;
        src_fixed    = 1'b0;
        dst_fixed    = 1'b0;
        m_grant      = 1'b0;
        m_din        = '0;
        prev_sel     = 1'b0;
        prev_wr      = 1'b0;
        test_reset();
        test_copy();
        test_alu_push();
        test_arbitration();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
